// File: rtl/register_file_param_if.sv
// Register file bus: one write port, three combinational read ports, ready flag.
interface register_file_param_if #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic            in_write_enable;
  logic [AW-1:0]   in_write_register_select;
  logic [XLEN-1:0] in_write_data;
  logic [AW-1:0]   in_read_register_select_0;
  logic [AW-1:0]   in_read_register_select_1;
  logic [AW-1:0]   in_read_register_select_2;
  logic [XLEN-1:0] out_read_data_0;
  logic [XLEN-1:0] out_read_data_1;
  logic [XLEN-1:0] out_read_data_2;
  logic            out_ready;

  // Requester side
  modport master (
    output in_write_enable, in_write_register_select, in_write_data,
    output in_read_register_select_0, in_read_register_select_1, in_read_register_select_2,
    input  out_read_data_0, out_read_data_1, out_read_data_2, out_ready
  );

  // Register file side
  modport slave (
    input  in_write_enable, in_write_register_select, in_write_data,
    input  in_read_register_select_0, in_read_register_select_1, in_read_register_select_2,
    output out_read_data_0, out_read_data_1, out_read_data_2, out_ready
  );
endinterface

// File: rtl/register_file_param.sv
// Parameterised 3-read/1-write register file with x0 hardwired to zero.
// After reset it walks addresses 1..NUM_REGS-1 writing zero (CLEAR), then
// accepts writes (READY). Reads are combinational and return 0 in CLEAR.
// Optional macro REGISTER_FILE_BYPASS_EN forwards same-cycle write data to
// matching read ports; without it reads see the stored value until next cycle.
module register_file_param #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  register_file_param_if.slave  bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0] mem_q [NUM_REGS];

  logic            mem_we_c;
  logic [AW-1:0]   mem_addr_c;
  logic [XLEN-1:0] mem_wdata_c;

  logic [AW-1:0]   rd_sel_c  [3];
  logic [XLEN-1:0] rd_data_c [3];

  // State and clear-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: leave CLEAR once the last address has been zeroed
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NUM_REGS - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Array write source: clear walker in CLEAR, user port in READY (never x0)
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state_q)
      CLEAR: begin
        mem_we_c   = 1'b1;
        mem_addr_c = clr_cnt_q;
      end
      READY: begin
        if (bus.in_write_enable && (bus.in_write_register_select != '0)) begin
          mem_we_c    = 1'b1;
          mem_addr_c  = bus.in_write_register_select;
          mem_wdata_c = bus.in_write_data;
        end
      end
      default: begin
        mem_we_c = 1'b0;
      end
    endcase
  end

  // Storage array; held off while reset is asserted
  always_ff @(posedge clk) begin
    if (!reset && mem_we_c) begin
      mem_q[mem_addr_c] <= mem_wdata_c;
    end
  end

  assign rd_sel_c[0] = bus.in_read_register_select_0;
  assign rd_sel_c[1] = bus.in_read_register_select_1;
  assign rd_sel_c[2] = bus.in_read_register_select_2;

  // Combinational read ports; zero in CLEAR and for x0
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rd_data_c[i] = '0;
      if ((state_q == READY) && (rd_sel_c[i] != '0)) begin
        rd_data_c[i] = mem_q[rd_sel_c[i]];
`ifdef REGISTER_FILE_BYPASS_EN
        if (bus.in_write_enable && (bus.in_write_register_select == rd_sel_c[i])) begin
          rd_data_c[i] = bus.in_write_data;
        end
`endif
      end
    end
  end

  assign bus.out_read_data_0 = rd_data_c[0];
  assign bus.out_read_data_1 = rd_data_c[1];
  assign bus.out_read_data_2 = rd_data_c[2];
  assign bus.out_ready       = (state_q == READY);

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: one 64x32 instance and one 32x16
// instance, the same scenarios applied to each in turn.
module tb_register_file_param;
`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_b, rst_s;
  logic        we_b, we_s;
  logic [4:0]  wsel, rs0, rs1, rs2;
  logic [63:0] wd;
  int          checks;
  int          failures;

  register_file_param_if #(.XLEN(64), .NUM_REGS(32)) bb ();
  register_file_param_if #(.XLEN(32), .NUM_REGS(16)) sb ();

  assign bb.in_write_enable           = we_b;
  assign bb.in_write_register_select  = wsel;
  assign bb.in_write_data             = wd;
  assign bb.in_read_register_select_0 = rs0;
  assign bb.in_read_register_select_1 = rs1;
  assign bb.in_read_register_select_2 = rs2;

  assign sb.in_write_enable           = we_s;
  assign sb.in_write_register_select  = wsel[3:0];
  assign sb.in_write_data             = wd[31:0];
  assign sb.in_read_register_select_0 = rs0[3:0];
  assign sb.in_read_register_select_1 = rs1[3:0];
  assign sb.in_read_register_select_2 = rs2[3:0];

  register_file_param #(.XLEN(64), .NUM_REGS(32)) u_big (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bb.slave)
  );

  register_file_param #(.XLEN(32), .NUM_REGS(16)) u_small (
    .clk   (clk),
    .reset (rst_s),
    .bus   (sb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nregs(input int inst);
    return (inst == 0) ? 32 : 16;
  endfunction

  function automatic logic [63:0] msk(input int inst, input logic [63:0] v);
    return (inst == 0) ? v : {32'h0, v[31:0]};
  endfunction

  function automatic logic rdy(input int inst);
    return (inst == 0) ? bb.out_ready : sb.out_ready;
  endfunction

  function automatic logic [63:0] rd(input int inst, input int p);
    logic [63:0] v;
    if (inst == 0) begin
      v = (p == 0) ? bb.out_read_data_0 : (p == 1) ? bb.out_read_data_1 : bb.out_read_data_2;
    end else begin
      v = {32'h0, (p == 0) ? sb.out_read_data_0 : (p == 1) ? sb.out_read_data_1 : sb.out_read_data_2};
    end
    return v;
  endfunction

  task automatic set_rst(input int inst, input logic v);
    if (inst == 0) rst_b = v; else rst_s = v;
  endtask

  task automatic set_we(input int inst, input logic v);
    if (inst == 0) we_b = v; else we_s = v;
  endtask

  // Counts cycles until out_ready rises; optionally pokes a write to x9 mid-clear
  task automatic do_clear(input int inst, input bit poke, input string tag);
    int n;
    n = 0;
    while (!rdy(inst) && n < 100) begin
      if (poke && n == 5) begin
        set_we(inst, 1'b1);
        wsel = 5'd9;
        wd   = 64'hAA;
        rs0  = 5'd9;
        #1;
        check($sformatf("%s_i%0d_clr_read", tag, inst), rd(inst, 0), 64'h0);
      end else begin
        set_we(inst, 1'b0);
      end
      tick();
      n++;
    end
    set_we(inst, 1'b0);
    check($sformatf("%s_i%0d_clr_len", tag, inst), 64'(n), 64'(nregs(inst) - 1));
  endtask

  task automatic run_all(input int inst);
    logic [63:0] v7;
    v7 = 64'hDEADBEEF_CAFEF00D;

    // Reset: outputs held low while asserted
    rs0 = 5'd5; rs1 = 5'd5; rs2 = 5'd5;
    set_rst(inst, 1'b1);
    tick();
    tick();
    check($sformatf("rst_i%0d_ready", inst), 64'(rdy(inst)), 64'h0);
    check($sformatf("rst_i%0d_rd0", inst), rd(inst, 0), 64'h0);
    set_rst(inst, 1'b0);
    do_clear(inst, 1'b1, "init");
    rs0 = 5'd5; rs1 = 5'd9;
    #1;
    check($sformatf("init_i%0d_ready", inst), 64'(rdy(inst)), 64'h1);
    check($sformatf("init_i%0d_x5", inst), rd(inst, 0), 64'h0);
    check($sformatf("init_i%0d_x9", inst), rd(inst, 1), 64'h0);

    // Basic write to x7, all ports reading it
    set_we(inst, 1'b1); wsel = 5'd7; wd = v7;
    rs0 = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    check($sformatf("wr7_i%0d_same", inst), rd(inst, 2), BYP ? msk(inst, v7) : 64'h0);
    tick();
    set_we(inst, 1'b0);
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("wr7_i%0d_p%0d", inst, p), rd(inst, p), msk(inst, v7));
    end

    // x0 write discarded, no bypass on x0
    set_we(inst, 1'b1); wsel = 5'd0; wd = '1;
    rs0 = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check($sformatf("x0_i%0d_same", inst), rd(inst, 1), 64'h0);
    tick();
    set_we(inst, 1'b0);
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("x0_i%0d_p%0d", inst, p), rd(inst, p), 64'h0);
    end

    // Same-cycle visibility on x3, port 0 still reads x7
    set_we(inst, 1'b1); wsel = 5'd3; wd = 64'h1234;
    rs0 = 5'd7; rs1 = 5'd3; rs2 = 5'd0;
    #1;
    check($sformatf("byp_i%0d_p1", inst), rd(inst, 1), BYP ? 64'h1234 : 64'h0);
    check($sformatf("byp_i%0d_p0", inst), rd(inst, 0), msk(inst, v7));
    tick();
    set_we(inst, 1'b0);
    #1;
    check($sformatf("byp_i%0d_next", inst), rd(inst, 1), 64'h1234);

    // Mid-operation reset after writing x12
    set_we(inst, 1'b1); wsel = 5'd12; wd = 64'h55;
    tick();
    set_we(inst, 1'b0);
    rs0 = 5'd12; rs1 = 5'd7; rs2 = 5'd3;
    #1;
    check($sformatf("x12_i%0d_wr", inst), rd(inst, 0), 64'h55);
    set_rst(inst, 1'b1);
    #1;
    check($sformatf("mrst_i%0d_ready", inst), 64'(rdy(inst)), 64'h0);
    check($sformatf("mrst_i%0d_rd", inst), rd(inst, 0), 64'h0);
    tick();
    set_rst(inst, 1'b0);
    do_clear(inst, 1'b0, "mrst");
    #1;
    check($sformatf("mrst_i%0d_x12", inst), rd(inst, 0), 64'h0);
    check($sformatf("mrst_i%0d_x7", inst), rd(inst, 1), 64'h0);
    check($sformatf("mrst_i%0d_x3", inst), rd(inst, 2), 64'h0);

    // Reset in the middle of CLEAR restarts the walk
    set_rst(inst, 1'b1);
    tick();
    set_rst(inst, 1'b0);
    repeat (8) tick();
    set_rst(inst, 1'b1);
    tick();
    check($sformatf("crst_i%0d_ready", inst), 64'(rdy(inst)), 64'h0);
    set_rst(inst, 1'b0);
    do_clear(inst, 1'b0, "crst");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_b = 1'b1; rst_s = 1'b1;
    we_b  = 1'b0; we_s  = 1'b0;
    wsel  = '0; wd = '0;
    rs0   = '0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    for (int inst = 0; inst < 2; inst++) begin
      run_all(inst);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
